// File: rtl/datamem_responder.sv
// datamem_responder: memory-side end of the load/store interface, one request outstanding, 2^ADDRBITS x 16-bit array.
// Latency: ack_o is high LATENCY cycles after accept (counting the cycle after the accepting edge as 1); posted writes ack after 1 with DATAMEM_WRBUF_EN.
// Backpressure: ready_o is low from accept until the cycle after ack; with DATAMEM_WRBUF_EN it is also low for a write while the buffer is full.
module datamem_responder #(
  parameter int LATENCY  = 2,
  parameter int ADDRBITS = 16
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                req_i,
  input  logic                we_i,
  input  logic [ADDRBITS-1:0] addr_i,
  input  logic [15:0]         wdata_i,
  output logic                ready_o,
  output logic                ack_o,
  output logic [15:0]         rdata_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);
  localparam int         DEPTH    = 1 << ADDRBITS;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                we_q;
  logic [ADDRBITS-1:0] addr_q;
  logic [15:0]         wdata_q;
  logic [15:0]         rdata_q, rdata_d;
  logic [15:0]         mem_q [DEPTH];

  logic                accept;
  logic                resp_we;
  logic                wr_blocked;
  logic                wr_posted;
  logic                mem_we;
  logic [ADDRBITS-1:0] rd_addr;
  logic [ADDRBITS-1:0] mem_waddr;
  logic [15:0]         rd_dat;
  logic [15:0]         mem_wdata;

  // With LATENCY == 1 the edge that accepts is also the edge entering RESP,
  // so the request fields are taken straight from the ports in IDLE.
  assign rd_addr = (state_q == IDLE) ? addr_i : addr_q;
  assign resp_we = (state_q == IDLE) ? we_i : we_q;
  assign accept  = req_i && ready_o;
  assign rdata_o = rdata_q;

`ifdef DATAMEM_WRBUF_EN
  localparam logic [3:0] WB_LOAD = 4'(LATENCY);

  logic                wb_valid_q;
  logic [3:0]          wb_cnt_q;
  logic [ADDRBITS-1:0] wb_addr_q;
  logic [15:0]         wb_data_q;
  logic                wb_drain;

  assign wr_blocked = we_i && wb_valid_q;
  assign wr_posted  = we_i;
  assign wb_drain   = wb_valid_q && (wb_cnt_q == 4'd1);
  // The buffer is the only memory writer in this build; reset discards it.
  assign mem_we     = wb_drain && !reset_i;
  assign mem_waddr  = wb_addr_q;
  assign mem_wdata  = wb_data_q;
  // Buffered data is newer than the array until the drain edge has passed.
  assign rd_dat     = (wb_valid_q && (wb_addr_q == rd_addr)) ? wb_data_q : mem_q[rd_addr];

  // Posted write buffer: load on an accepted write, drain LATENCY edges later.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wb_valid_q <= 1'b0;
      wb_cnt_q   <= 4'd0;
      wb_addr_q  <= '0;
      wb_data_q  <= 16'h0000;
    end else if (accept && we_i) begin
      wb_valid_q <= 1'b1;
      wb_cnt_q   <= WB_LOAD;
      wb_addr_q  <= addr_i;
      wb_data_q  <= wdata_i;
    end else if (wb_valid_q) begin
      if (wb_cnt_q == 4'd1) begin
        wb_valid_q <= 1'b0;
        wb_cnt_q   <= 4'd0;
      end else begin
        wb_cnt_q   <= wb_cnt_q - 4'd1;
      end
    end
  end
`else
  assign wr_blocked = 1'b0;
  assign wr_posted  = 1'b0;
  // A write commits on the edge leaving RESP, unless reset drops it.
  assign mem_we     = (state_q == RESP) && we_q && !reset_i;
  assign mem_waddr  = addr_q;
  assign mem_wdata  = wdata_q;
  assign rd_dat     = mem_q[rd_addr];
`endif

  // Next-state, handshake outputs and read-data capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    ready_o = 1'b0;
    ack_o   = 1'b0;
    case (state_q)
      IDLE: begin
        ready_o = !reset_i && !wr_blocked;
        if (req_i && ready_o) begin
          if ((LATENCY == 1) || wr_posted) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = RESP;
        end
      end
      RESP: begin
        ack_o   = !reset_i;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // rdata is loaded only on the edge entering RESP; a write ack returns zero.
    if ((state_d == RESP) && (state_q != RESP)) begin
      rdata_d = resp_we ? 16'h0000 : rd_dat;
    end
  end

  // Control and request registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 16'h0000;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      if (accept) begin
        we_q    <= we_i;
        addr_q  <= addr_i;
        wdata_q <= wdata_i;
      end
    end
  end

  // Storage array; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

endmodule
